// File: rtl/tcb_lib_pkg.sv
// Shared definitions for the TCB library blocks: response-pipeline stage
// record and latency/select limits.
package tcb_lib_pkg;

  // Longest supported fixed response latency.
  localparam int unsigned TCB_DLY_MAX = 4;

  // Widest port select a stage record can carry (up to 256 ports).
  localparam int unsigned TCB_MPL_MAX = 8;

  // One entry of the response steering pipeline.
  typedef struct packed {
    logic                   act;      // a transfer was accepted in this slot
    logic                   dec_err;  // the transfer hit no existing port
    logic [TCB_MPL_MAX-1:0] sel;      // port that accepted the transfer
  } tcb_dmx_stage_t;

  // True when a select value addresses no existing port.
  function automatic logic tcb_sel_out_of_range(input int unsigned sel, input int unsigned mpn);
    if (sel >= mpn) begin
      return 1'b1;
    end else begin
      return 1'b0;
    end
  endfunction

endpackage

// File: rtl/tcb_lib_delay_line.sv
// Generic fixed-length shift register used to align response steering with
// the response latency. DLY = 0 degenerates to a wire.
module tcb_lib_delay_line #(
  parameter type         T   = logic,
  parameter int unsigned DLY = 1
)(
  input  logic clk,
  input  logic rst,
  input  T     din,
  output T     dout
);

  generate
    if (DLY == 0) begin : g_bypass
      logic unused_clk_rst_s;
      assign unused_clk_rst_s = clk ^ rst;
      assign dout = din;
    end else begin : g_pipe
      T pipe_r [DLY];

      // Shift every cycle; active-low synchronous clear empties all stages.
      always_ff @(posedge clk) begin
        if (!rst) begin
          for (int i = 0; i < int'(DLY); i++) begin
            pipe_r[i] <= '0;
          end
        end else begin
          pipe_r[0] <= din;
          for (int i = 1; i < int'(DLY); i++) begin
            pipe_r[i] <= pipe_r[i-1];
          end
        end
      end

      assign dout = pipe_r[DLY-1];
    end
  endgenerate

endmodule

// File: rtl/tcb_lib_demultiplexer_chk.sv
// Simulation-only checks for the demultiplexer request fan-out.
module tcb_lib_demultiplexer_chk #(
  parameter int unsigned MPN = 3
)(
  input logic           clk,
  input logic           rst,
  input logic [MPN-1:0] vld
);

  // At most one downstream port may see a valid request in any cycle.
  man_vld_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(vld))
    else $error("tcb_lib_demultiplexer: more than one man.vld high: %b", vld);

endmodule

// File: rtl/tcb_lib_demultiplexer.sv
// Routes one TCB manager to one of MPN subordinate ports chosen by sel.
// Requests pass combinationally; responses return DLY cycles later and are
// steered back from the port that accepted the matching request. Selects
// beyond the last port are accepted locally and answered with an error.
module tcb_lib_demultiplexer
  import tcb_lib_pkg::*;
#(
  parameter int unsigned ADR = 32,
  parameter int unsigned DAT = 32,
  parameter int unsigned SLW = 8,
  parameter int unsigned BEN = DAT/SLW,
  parameter int unsigned DLY = 1,
  parameter int unsigned MPN = 3,
  parameter int unsigned MPL = (MPN > 1) ? $clog2(MPN) : 1
)(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [MPL-1:0]           sel,
  // upstream manager
  input  logic                     sub_vld,
  input  logic                     sub_wen,
  input  logic [ADR-1:0]           sub_adr,
  input  logic [BEN-1:0]           sub_ben,
  input  logic [DAT-1:0]           sub_wdt,
  output logic [DAT-1:0]           sub_rdt,
  output logic                     sub_err,
  output logic                     sub_rdy,
  // downstream subordinates
  output logic [MPN-1:0]           man_vld,
  output logic [MPN-1:0]           man_wen,
  output logic [MPN-1:0][ADR-1:0]  man_adr,
  output logic [MPN-1:0][BEN-1:0]  man_ben,
  output logic [MPN-1:0][DAT-1:0]  man_wdt,
  input  logic [MPN-1:0][DAT-1:0]  man_rdt,
  input  logic [MPN-1:0]           man_err,
  input  logic [MPN-1:0]           man_rdy
);

  logic           dec_err_s;
  logic           transfer_s;
  tcb_dmx_stage_t stage_in_s;
  tcb_dmx_stage_t stage_out_s;

  assign dec_err_s  = tcb_sel_out_of_range(int'(sel), MPN);
  assign transfer_s = sub_vld & sub_rdy;

  // Route vld to the selected port and take its rdy; out-of-range selects are
  // always ready so the error completes locally. Reset blocks all handshakes.
  always_comb begin
    man_vld = '0;
    sub_rdy = 1'b0;
    if (!rst) begin
      man_vld = '0;
      sub_rdy = 1'b0;
    end else if (dec_err_s) begin
      sub_rdy = 1'b1;
    end else begin
      for (int i = 0; i < int'(MPN); i++) begin
        if (int'(sel) == i) begin
          man_vld[i] = sub_vld;
          sub_rdy    = man_rdy[i];
        end else begin
          man_vld[i] = 1'b0;
        end
      end
    end
  end

  // Request payload is broadcast; only vld distinguishes the target port.
  always_comb begin
    for (int i = 0; i < int'(MPN); i++) begin
      man_wen[i] = sub_wen;
      man_adr[i] = sub_adr;
      man_ben[i] = sub_ben;
      man_wdt[i] = sub_wdt;
    end
  end

  // Build the steering record for the current cycle; a stall records act = 0.
  always_comb begin
    stage_in_s              = '0;
    stage_in_s.act          = transfer_s;
    stage_in_s.dec_err      = dec_err_s;
    stage_in_s.sel[MPL-1:0] = sel;
  end

  tcb_lib_delay_line #(
    .T   (tcb_dmx_stage_t),
    .DLY (DLY)
  ) u_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (stage_in_s),
    .dout (stage_out_s)
  );

  // Steer the response from the port recorded for this slot; idle slots and
  // cycles under reset return zero, decode errors return err with zero data.
  always_comb begin
    sub_rdt = '0;
    sub_err = 1'b0;
    if (!rst) begin
      sub_rdt = '0;
      sub_err = 1'b0;
    end else if (!stage_out_s.act) begin
      sub_rdt = '0;
      sub_err = 1'b0;
    end else if (stage_out_s.dec_err) begin
      sub_rdt = '0;
      sub_err = 1'b1;
    end else begin
      for (int i = 0; i < int'(MPN); i++) begin
        if (int'(stage_out_s.sel) == i) begin
          sub_rdt = man_rdt[i];
          sub_err = man_err[i];
        end else begin
        end
      end
    end
  end

  tcb_lib_demultiplexer_chk #(
    .MPN (MPN)
  ) u_chk (
    .clk (clk),
    .rst (rst),
    .vld (man_vld)
  );

endmodule

// File: tb/tb_tcb_lib_demultiplexer.sv
// Bench for tcb_lib_demultiplexer: three instances (DLY = 0, 1, 2) share the
// same stimulus; a cycle-history reference model predicts every output.
module tb_tcb_lib_demultiplexer;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        sel;
  logic              vld, wen;
  logic [31:0]       adr, wdt;
  logic [3:0]        ben;
  logic [2:0][31:0]  man_rdt;
  logic [2:0]        man_err, man_rdy;

  logic [31:0]       o_rdt [3];
  logic              o_err [3];
  logic              o_rdy [3];
  logic [2:0]        o_vld [3];
  logic [2:0]        o_wen [3];
  logic [2:0][31:0]  o_adr [3];
  logic [2:0][3:0]   o_ben [3];
  logic [2:0][31:0]  o_wdt [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    tcb_lib_demultiplexer #(.DLY(g)) u_dut (
      .clk(clk), .rst(rst), .sel(sel),
      .sub_vld(vld), .sub_wen(wen), .sub_adr(adr), .sub_ben(ben), .sub_wdt(wdt),
      .sub_rdt(o_rdt[g]), .sub_err(o_err[g]), .sub_rdy(o_rdy[g]),
      .man_vld(o_vld[g]), .man_wen(o_wen[g]), .man_adr(o_adr[g]), .man_ben(o_ben[g]),
      .man_wdt(o_wdt[g]), .man_rdt(man_rdt), .man_err(man_err), .man_rdy(man_rdy)
    );
  end

  // reference model state: one entry per simulated cycle
  int          tests_run = 0;
  int          tests_failed = 0;
  int          cyc = 0;
  logic        rst_h  [4096];
  logic        xfer_h [4096];
  logic [1:0]  sel_h  [4096];
  logic        exp_rdy;
  logic [2:0]  exp_vld;
  logic [31:0] exp_rdt [3];
  logic        exp_err [3];

  localparam logic [2:0][31:0] RD = {32'h23222120, 32'h13121110, 32'h03020100};

  function automatic logic [2:0][31:0] rnd3();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  // Apply one cycle of inputs after the falling edge, then predict outputs:
  // a transfer needs reset released, vld, and either an invalid select or the
  // selected port ready; a response for latency d shows the port data of the
  // transfer d cycles back unless reset was seen since then.
  task automatic drive(input logic r, input logic v, input logic [1:0] s, input logic w,
                       input logic [2:0] rdy, input logic [2:0][31:0] rdt, input logic [2:0] err);
    logic ok;
    int   src;
    @(negedge clk);
    rst = r; vld = v; sel = s; wen = w;
    adr = $urandom(); wdt = $urandom(); ben = 4'($urandom_range(15, 0));
    man_rdy = rdy; man_rdt = rdt; man_err = err;
    #1;
    rst_h[cyc] = r;
    exp_rdy = r && ((s == 2'd3) || rdy[s]);
    exp_vld = (r && v && s != 2'd3) ? (3'b001 << s) : 3'b000;
    xfer_h[cyc] = v && exp_rdy;
    sel_h[cyc]  = s;
    for (int d = 0; d < 3; d++) begin
      src = cyc - d;
      ok  = r && (src >= 0);
      if (ok) begin
        ok = xfer_h[src];
        for (int k = src + 1; k <= cyc; k++) if (!rst_h[k]) ok = 1'b0;
      end
      exp_rdt[d] = 32'h0;
      exp_err[d] = 1'b0;
      if (ok && sel_h[src] == 2'd3) exp_err[d] = 1'b1;
      else if (ok) begin
        exp_rdt[d] = rdt[sel_h[src]];
        exp_err[d] = err[sel_h[src]];
      end
    end
    cyc++;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 2'($urandom_range(3, 0)), 1'b1, 3'b111, rnd3(), 3'b111);
      for (int d = 0; d < 3; d++) begin
        tests_run++; if (o_vld[d] !== 3'b000) begin tests_failed++; $display("FAIL reset_vld d%0d: got %b want 000", d, o_vld[d]); end
        tests_run++; if (o_rdy[d] !== 1'b0) begin tests_failed++; $display("FAIL reset_rdy d%0d: got %b want 0", d, o_rdy[d]); end
        tests_run++; if (o_rdt[d] !== 32'h0 || o_err[d] !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp d%0d: got %h/%b want 0/0", d, o_rdt[d], o_err[d]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b1, 2'd0, 1'b1, 3'b111, RD, 3'b000);
    tests_run++; if (o_vld[1] !== 3'b001 || o_rdy[1] !== 1'b1) begin tests_failed++; $display("FAIL b2b_wr_req: got vld %b rdy %b want 001 1", o_vld[1], o_rdy[1]); end
    drive(1'b1, 1'b1, 2'd2, 1'b0, 3'b111, RD, 3'b000);
    tests_run++; if (o_vld[1] !== 3'b100 || o_rdy[1] !== 1'b1) begin tests_failed++; $display("FAIL b2b_rd_req: got vld %b rdy %b want 100 1", o_vld[1], o_rdy[1]); end
    tests_run++; if (o_rdt[0] !== 32'h23222120) begin tests_failed++; $display("FAIL b2b_dly0_rdt: got %h want 23222120", o_rdt[0]); end
    drive(1'b1, 1'b0, 2'd0, 1'b0, 3'b111, RD, 3'b000);
    tests_run++; if (o_rdt[1] !== 32'h23222120 || o_err[1] !== 1'b0) begin tests_failed++; $display("FAIL b2b_rd_rsp: got %h/%b want 23222120/0", o_rdt[1], o_err[1]); end
    tests_run++; if (o_vld[1] !== 3'b000) begin tests_failed++; $display("FAIL b2b_idle_vld: got %b want 000", o_vld[1]); end
  endtask

  task automatic test_stall();
    drive(1'b1, 1'b0, 2'd0, 1'b0, 3'b111, RD, 3'b000);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 2'd1, 1'b0, 3'b101, RD, 3'b000);
      tests_run++; if (o_rdy[1] !== 1'b0 || o_vld[1] !== 3'b010) begin tests_failed++; $display("FAIL stall_req c%0d: got rdy %b vld %b want 0 010", i, o_rdy[1], o_vld[1]); end
      tests_run++; if (o_rdt[1] !== 32'h0 || o_err[1] !== 1'b0 || o_rdt[2] !== 32'h0) begin tests_failed++; $display("FAIL stall_rsp c%0d: got %h/%b %h want 0", i, o_rdt[1], o_err[1], o_rdt[2]); end
    end
    drive(1'b1, 1'b1, 2'd1, 1'b0, 3'b111, RD, 3'b000);
    tests_run++; if (o_rdy[1] !== 1'b1) begin tests_failed++; $display("FAIL stall_release: got rdy %b want 1", o_rdy[1]); end
    drive(1'b1, 1'b0, 2'd0, 1'b0, 3'b111, RD, 3'b010);
    tests_run++; if (o_rdt[1] !== 32'h13121110 || o_err[1] !== 1'b1) begin tests_failed++; $display("FAIL stall_rsp_d1: got %h/%b want 13121110/1", o_rdt[1], o_err[1]); end
    drive(1'b1, 1'b0, 2'd0, 1'b0, 3'b111, RD, 3'b000);
    tests_run++; if (o_rdt[2] !== 32'h13121110) begin tests_failed++; $display("FAIL stall_rsp_d2: got %h want 13121110", o_rdt[2]); end
  endtask

  task automatic test_decode_error();
    logic [2:0][31:0] rr;
    rr = rnd3();
    drive(1'b1, 1'b1, 2'd3, 1'b0, 3'b000, rr, 3'b000);
    tests_run++; if (o_vld[1] !== 3'b000 || o_rdy[1] !== 1'b1) begin tests_failed++; $display("FAIL decerr_req: got vld %b rdy %b want 000 1", o_vld[1], o_rdy[1]); end
    tests_run++; if (o_err[0] !== 1'b1 || o_rdt[0] !== 32'h0) begin tests_failed++; $display("FAIL decerr_d0: got %h/%b want 0/1", o_rdt[0], o_err[0]); end
    drive(1'b1, 1'b0, 2'd0, 1'b0, 3'b111, rr, 3'b000);
    tests_run++; if (o_err[1] !== 1'b1 || o_rdt[1] !== 32'h0) begin tests_failed++; $display("FAIL decerr_d1: got %h/%b want 0/1", o_rdt[1], o_err[1]); end
  endtask

  task automatic test_dly2_order();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, (i < 3), 2'(i % 3), 1'b0, 3'b111, RD, 3'b000);
      if (i >= 2) begin
        tests_run++; if (o_rdt[2] !== RD[i-2] || o_err[2] !== 1'b0) begin tests_failed++; $display("FAIL dly2_order T+%0d: got %h/%b want %h/0", i, o_rdt[2], o_err[2], RD[i-2]); end
      end
    end
  endtask

  task automatic test_reset_midflight();
    drive(1'b1, 1'b1, 2'd1, 1'b0, 3'b111, RD, 3'b010);
    drive(1'b0, 1'b0, 2'd0, 1'b0, 3'b111, RD, 3'b010);
    tests_run++; if (o_rdt[2] !== 32'h0 || o_err[2] !== 1'b0) begin tests_failed++; $display("FAIL midrst_in_reset: got %h/%b want 0/0", o_rdt[2], o_err[2]); end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 2'd0, 1'b0, 3'b111, RD, 3'b010);
      tests_run++; if (o_rdt[2] !== 32'h0 || o_err[2] !== 1'b0) begin tests_failed++; $display("FAIL midrst_dropped c%0d: got %h/%b want 0/0", i, o_rdt[2], o_err[2]); end
    end
    drive(1'b1, 1'b1, 2'd1, 1'b0, 3'b111, RD, 3'b000);
    drive(1'b1, 1'b0, 2'd0, 1'b0, 3'b111, RD, 3'b000);
    drive(1'b1, 1'b0, 2'd0, 1'b0, 3'b111, RD, 3'b000);
    tests_run++; if (o_rdt[2] !== 32'h13121110 || o_err[2] !== 1'b0) begin tests_failed++; $display("FAIL midrst_recover: got %h/%b want 13121110/0", o_rdt[2], o_err[2]); end
  endtask

  task automatic test_dly0();
    drive(1'b1, 1'b1, 2'd1, 1'b0, 3'b111, {32'h0, 32'h89ABCDEF, 32'h0}, 3'b000);
    tests_run++; if (o_rdt[0] !== 32'h89ABCDEF || o_err[0] !== 1'b0) begin tests_failed++; $display("FAIL dly0_rsp: got %h/%b want 89abcdef/0", o_rdt[0], o_err[0]); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(19, 0) != 0), 1'($urandom()), 2'($urandom_range(3, 0)), 1'($urandom()),
            3'($urandom()), rnd3(), 3'($urandom()));
      for (int d = 0; d < 3; d++) begin
        tests_run++; if (o_vld[d] !== exp_vld || o_rdy[d] !== exp_rdy) begin tests_failed++; $display("FAIL rnd_req d%0d cyc%0d: got vld %b rdy %b want %b %b", d, cyc, o_vld[d], o_rdy[d], exp_vld, exp_rdy); end
        tests_run++; if (o_rdt[d] !== exp_rdt[d] || o_err[d] !== exp_err[d]) begin tests_failed++; $display("FAIL rnd_rsp d%0d cyc%0d: got %h/%b want %h/%b", d, cyc, o_rdt[d], o_err[d], exp_rdt[d], exp_err[d]); end
        tests_run++; if (o_adr[d] !== {3{adr}} || o_wdt[d] !== {3{wdt}} || o_ben[d] !== {3{ben}} || o_wen[d] !== {3{wen}}) begin tests_failed++; $display("FAIL rnd_bcast d%0d cyc%0d: got adr %h wdt %h ben %h wen %b", d, cyc, o_adr[d], o_wdt[d], o_ben[d], o_wen[d]); end
      end
    end
  endtask

  initial begin
    rst = 1'b0; vld = 1'b0; sel = 2'd0; wen = 1'b0;
    adr = 32'h0; wdt = 32'h0; ben = 4'h0;
    man_rdt = '0; man_err = 3'b000; man_rdy = 3'b000;
    test_reset();
    test_back_to_back();
    test_stall();
    test_decode_error();
    test_dly2_order();
    test_reset_midflight();
    test_dly0();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
